param_bank: RTL
===============

// Module: param_bank
// PURPOSE
// - Double-buffered (shadow/active) parameter store between the SPI host interface and the DSP core.
// - Host writes/reads hit the shadow bank; the DSP core reads the active bank.
// - A host commit swaps the banks atomically at the next audio frame boundary, so the DSP never sees a half-updated parameter set.
// - Optional copy-back refreshes the new shadow from the new active bank after each swap.
// PARAMETERS
// - PARAM_WIDTH  36  width of one parameter word.
// - ADDR_WIDTH   8   parameter address width; DEPTH = 2**ADDR_WIDTH words per bank (localparam).
// PORTS
// - clk           in   1            system clock; single clock domain.
// - reset         in   1            asynchronous, active-high reset.
// - host_wr_addr  in   ADDR_WIDTH   shadow write address (from SPI slave wr_addr).
// - host_wr_data  in   PARAM_WIDTH  shadow write data.
// - host_wr_en    in   1            1-cycle write strobe.
// - host_rd_addr  in   ADDR_WIDTH   shadow read address (from SPI slave rd_addr).
// - host_rd_data  out  PARAM_WIDTH  shadow read data, 1-cycle latency.
// - commit        in   1            1-cycle pulse: request bank swap.
// - frame_sync    in   1            1-cycle pulse from audio core at frame boundary.
// - dsp_rd_addr   in   ADDR_WIDTH   active-bank read address.
// - dsp_rd_data   out  PARAM_WIDTH  active-bank read data, 1-cycle latency.
// - active_bank   out  1            index of the bank the DSP currently reads.
// - busy          out  1            high in PENDING or COPY.
// - swap_done     out  1            1-cycle pulse, cycle after the swap edge.
// - wr_overrun    out  1            sticky: a host write was dropped during COPY.
// BEHAVIOUR
// - Reset (async): state=IDLE, active_bank=0, busy=0, swap_done=0, wr_overrun=0, commit_latched=0, read-data registers=0.
// - Reset does not clear RAM contents; RAM is initialised to 0 at configuration.
// - FSM states:
//   - IDLE: commit -> PENDING.
//   - PENDING: frame_sync -> toggle active_bank, pulse swap_done next cycle, go to COPY (or IDLE, see CONFIGURATION).
//   - COPY: runs DEPTH+1 cycles, then -> IDLE, or -> PENDING if commit_latched.
// - commit in PENDING: ignored.
// - commit in COPY: sets commit_latched; it is consumed on COPY exit.
// - commit and frame_sync in the same IDLE cycle: go to PENDING only; the swap happens on a later frame_sync, never in that same cycle.
// - Host writes in IDLE/PENDING: written to the shadow bank (~active_bank).
// - Host write in the same cycle as the swap: lands in the old shadow, i.e. the new active bank, and is included in the swap.
// - Host writes in COPY: dropped; wr_overrun set. wr_overrun clears on the next accepted commit (IDLE->PENDING).
// - COPY engine:
//   - Address counter 0..DEPTH-1 reads the active bank.
//   - The returned word is written to the shadow bank at the same address one cycle later.
//   - Last write occurs in cycle DEPTH; the counter wraps to 0 and does not advance past DEPTH-1.
// - Reads:
//   - dsp_rd_data = active[dsp_rd_addr] registered, 1 cycle.
//   - host_rd_data = shadow[host_rd_addr] registered, 1 cycle.
//   - The bank mapping follows active_bank as sampled in the address cycle.
// - Read-during-write on the same bank and address returns the old data.
// - frame_sync outside PENDING: no effect.
// CONFIGURATION
// - PARAM_BANK_COPYBACK_EN defined:
//   - COPY state present; after a swap, the shadow becomes an exact copy of the new active bank.
// - PARAM_BANK_COPYBACK_EN undefined:
//   - No COPY state; PENDING -> IDLE on swap.
//   - The shadow keeps stale pre-swap contents; the host must rewrite the full set.
//   - busy = PENDING only; wr_overrun is tied to 0.
// STRUCTURE
// - Package param_bank_pkg:
//   - state enum {IDLE, PENDING, COPY}.
//   - typedefs param_t (logic[PARAM_WIDTH-1:0]) and addr_t, shared with the SPI slave and DSP core.
// - Sub-module param_bank_ram, instantiated twice (bank 0, bank 1):
//   - DEPTH x PARAM_WIDTH, 1 write port, 2 registered read ports.
//   - Read port A: dsp_rd_addr if the bank is active, else host_rd_addr.
//   - Read port B: copy source address.
// - Top level: FSM, copy counter, commit latch, write-port steering.
// TESTING
// - Shadow isolation: write 0x123456789 @5 in IDLE -> dsp_rd_data @5 stays 0; host_rd_data @5 = 0x123456789 one cycle after the read address.
// - Swap: commit, then frame_sync 10 cycles later -> active_bank 0->1 on that edge; swap_done pulses next cycle; dsp_rd_data @5 = 0x123456789.
// - Copy-back (EN): after the swap, busy stays high DEPTH+1 cycles; then host_rd_data at every address equals dsp_rd_data; wr_overrun = 0.
// - Overrun: host write @7 during COPY -> dropped, wr_overrun = 1; next commit clears it; the @7 shadow value equals the active value.
// - Simultaneous: commit and frame_sync in the same IDLE cycle -> no swap; the next frame_sync swaps. commit during COPY -> PENDING immediately after COPY.
// - Reset mid-COPY: assert reset at counter = 100 -> active_bank = 0, busy = 0, state IDLE; a later commit + frame_sync operates normally.

Source files
------------

// File: rtl/param_bank_pkg.sv
// Shared types for the double-buffered parameter store: word/address typedefs
// used by the SPI slave and DSP core, plus the bank controller state encoding.
package param_bank_pkg;

    localparam int PARAM_W = 36;
    localparam int ADDR_W  = 8;
    localparam int DEPTH_W = 2**ADDR_W;

    typedef logic [PARAM_W-1:0] param_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COPY
    } state_t;

endpackage

// File: rtl/param_bank_ram.sv
// One parameter bank: single write port, two registered read ports with
// read-old-data behaviour on a same-address collision.
module param_bank_ram
    import param_bank_pkg::*;
#(
    parameter int PARAM_WIDTH = PARAM_W,
    parameter int ADDR_WIDTH  = ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [PARAM_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]  rd_a_addr,
    output logic [PARAM_WIDTH-1:0] rd_a_data,
    input  logic [ADDR_WIDTH-1:0]  rd_b_addr,
    output logic [PARAM_WIDTH-1:0] rd_b_data
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [PARAM_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Port A feeds the externally visible read data, so it is cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_data <= '0;
        end else begin
            rd_a_data <= mem[rd_a_addr];
        end
    end

    always_ff @(posedge clk) begin
        rd_b_data <= mem[rd_b_addr];
    end

endmodule

// File: rtl/param_bank.sv
// Shadow/active parameter store with frame-aligned bank swap. Defining
// PARAM_BANK_COPYBACK_EN adds the post-swap copy of active into shadow.
module param_bank
    import param_bank_pkg::*;
#(
    parameter int PARAM_WIDTH = PARAM_W,
    parameter int ADDR_WIDTH  = ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  host_wr_addr,
    input  logic [PARAM_WIDTH-1:0] host_wr_data,
    input  logic                   host_wr_en,
    input  logic [ADDR_WIDTH-1:0]  host_rd_addr,
    output logic [PARAM_WIDTH-1:0] host_rd_data,
    input  logic                   commit,
    input  logic                   frame_sync,
    input  logic [ADDR_WIDTH-1:0]  dsp_rd_addr,
    output logic [PARAM_WIDTH-1:0] dsp_rd_data,
    output logic                   active_bank,
    output logic                   busy,
    output logic                   swap_done,
    output logic                   wr_overrun
);

    localparam logic [ADDR_WIDTH:0] CP_LAST = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CP_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                 state, state_nxt;
    logic                   commit_latched;
    logic [ADDR_WIDTH:0]    cp_cnt_p0;
    logic                   vld_p1;
    logic [ADDR_WIDTH-1:0]  cp_addr_p1;
    logic                   sel_p1;
    logic                   swap, cp_done, host_wr_ok;
    logic                   sh_wr_en;
    logic [ADDR_WIDTH-1:0]  sh_wr_addr;
    logic [PARAM_WIDTH-1:0] sh_wr_data, cp_data;
    logic [PARAM_WIDTH-1:0] rd_a0, rd_a1, rd_b0, rd_b1;

    assign swap       = (state == PENDING) && frame_sync;
    assign cp_done    = (cp_cnt_p0 == CP_LAST);
    assign host_wr_ok = host_wr_en && (state != COPY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit) state_nxt = PENDING;
`ifdef PARAM_BANK_COPYBACK_EN
            PENDING: if (frame_sync) state_nxt = COPY;
`else
            PENDING: if (frame_sync) state_nxt = IDLE;
`endif
            COPY:    if (cp_done) state_nxt = (commit_latched || commit) ? PENDING : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: FSM, bank select and copy counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            active_bank    <= 1'b0;
            swap_done      <= 1'b0;
            commit_latched <= 1'b0;
            cp_cnt_p0      <= '0;
            vld_p1         <= 1'b0;
            sel_p1         <= 1'b0;
        end else begin
            state     <= state_nxt;
            swap_done <= swap;
            sel_p1    <= active_bank;
            vld_p1    <= (state == COPY) && !cp_done;
            if (swap) begin
                active_bank <= ~active_bank;
            end
            if (state == COPY && !cp_done) begin
                cp_cnt_p0 <= cp_cnt_p0 + CP_ONE;
                if (commit) commit_latched <= 1'b1;
            end else begin
                cp_cnt_p0      <= '0;
                commit_latched <= 1'b0;
            end
        end
    end

    // p1: copy write-back address, one cycle behind the source read
    always_ff @(posedge clk) begin
        cp_addr_p1 <= cp_cnt_p0[ADDR_WIDTH-1:0];
    end

`ifdef PARAM_BANK_COPYBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_overrun <= 1'b0;
        end else if (state == IDLE && commit) begin
            wr_overrun <= 1'b0;
        end else if (state == COPY && host_wr_en) begin
            wr_overrun <= 1'b1;
        end
    end
    assign busy = (state != IDLE);
`else
    assign wr_overrun = 1'b0;
    assign busy       = (state == PENDING);
`endif

    // The shadow port is shared: copy engine in COPY, host otherwise.
    assign cp_data    = active_bank ? rd_b1 : rd_b0;
    assign sh_wr_en   = host_wr_ok || vld_p1;
    assign sh_wr_addr = vld_p1 ? cp_addr_p1 : host_wr_addr;
    assign sh_wr_data = vld_p1 ? cp_data : host_wr_data;

    param_bank_ram #(.PARAM_WIDTH(PARAM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (sh_wr_en && active_bank),
        .wr_addr   (sh_wr_addr),
        .wr_data   (sh_wr_data),
        .rd_a_addr (active_bank ? host_rd_addr : dsp_rd_addr),
        .rd_a_data (rd_a0),
        .rd_b_addr (cp_cnt_p0[ADDR_WIDTH-1:0]),
        .rd_b_data (rd_b0)
    );

    param_bank_ram #(.PARAM_WIDTH(PARAM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (sh_wr_en && !active_bank),
        .wr_addr   (sh_wr_addr),
        .wr_data   (sh_wr_data),
        .rd_a_addr (active_bank ? dsp_rd_addr : host_rd_addr),
        .rd_a_data (rd_a1),
        .rd_b_addr (cp_cnt_p0[ADDR_WIDTH-1:0]),
        .rd_b_data (rd_b1)
    );

    assign dsp_rd_data  = sel_p1 ? rd_a1 : rd_a0;
    assign host_rd_data = sel_p1 ? rd_a0 : rd_a1;

endmodule
